// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boot_pkg
//  Description : Shared types and helpers for the imem boot loader. Holds the
//                loader state enum, the stream-bytes-per-word constant and a
//                little-endian byte-lane insert function.
//  Revision    : 1.0  initial release
// ============================================================================
package boot_pkg;

    typedef enum logic [1:0] {
        LEN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } boot_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Returns i_word with byte lane i_idx replaced by i_data (lane k = bits [8k+7:8k]).
    function automatic logic [31:0] le_byte_insert(
        input logic [31:0] i_word,
        input logic [1:0]  i_idx,
        input logic [7:0]  i_data
    );
        logic [31:0] w_word;
        w_word                = i_word;
        w_word[8*i_idx +: 8]  = i_data;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_boot_ctrl_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Assembles an accepted byte stream into 32-bit little-endian
//                words. o_word is the word including the byte currently on
//                i_data, so o_word is complete in the same cycle o_word_valid
//                pulses (fourth byte accepted).
//  Ports       : clk, reset   - clock / synchronous active-high reset
//                i_clear      - return to byte lane 0 and drop partial word
//                i_accept     - i_data is consumed this cycle
//                i_data       - stream byte
//                o_word       - assembled word (valid with o_word_valid)
//                o_word_valid - single-cycle pulse on the fourth byte
//  Revision    : 1.0  initial release
// ============================================================================
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_data,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    localparam logic [1:0] c_LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  r_idx;
    logic [31:0] r_word;

    assign o_word       = le_byte_insert(r_word, r_idx, i_data);
    assign o_word_valid = i_accept && (r_idx == c_LAST_IDX);

    // Index wraps 3->0 naturally, so the next group starts at lane 0.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_accept) begin
            r_idx  <= r_idx + 2'd1;
            r_word <= o_word;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_ctrl
//  Description : Instruction-memory boot sequencer. Parses a 4-byte LE length
//                header from a valid/ready byte stream, writes the following
//                words to imem from word address 0, and holds the core in
//                reset until the load completes.
//  Ports       : clk, reset            - clock / synchronous active-high reset
//                rx_valid/rx_data/rx_ready - byte stream handshake
//                reload                - restart loading from DONE or ERR
//                imem_we/addr/wdata    - imem write port (one-cycle strobe)
//                core_reset            - core reset, low only in DONE
//                load_done, load_err   - status
//                word_count            - words written since LEN entry
//  Revision    : 1.0  initial release
// ============================================================================
module imem_boot_ctrl
    import boot_pkg::*;
#(
    parameter int          ADDR_W    = 28,
    parameter logic [32:0] MAX_WORDS = 33'(1) << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [31:0]       word_count
);

    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;

    boot_state_t       r_state,      w_state_nxt;
    logic              r_rx_ready,   w_rx_ready_nxt;
    logic              r_we,         w_we_nxt;
    logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
    logic [31:0]       r_wdata,      w_wdata_nxt;
    logic [31:0]       r_count,      w_count_nxt;
    logic [31:0]       r_len,        w_len_nxt;
    logic              r_core_reset, w_core_reset_nxt;

    logic              w_accept;
    logic              w_clear;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic [31:0]       w_count_inc;

    assign w_accept = rx_valid && r_rx_ready;

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_clear),
        .i_accept     (w_accept),
        .i_data       (rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= LEN;
            r_rx_ready   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_count      <= '0;
            r_len        <= '0;
            r_core_reset <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_rx_ready   <= w_rx_ready_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_count      <= w_count_nxt;
            r_len        <= w_len_nxt;
            r_core_reset <= w_core_reset_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_rx_ready_nxt   = r_rx_ready;
        w_we_nxt         = 1'b0;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_count_nxt      = r_count;
        w_len_nxt        = r_len;
        w_core_reset_nxt = 1'b1;
        w_clear          = 1'b0;
        w_count_inc      = r_count + 32'd1;

        case (r_state)
            LEN: begin
                w_rx_ready_nxt = 1'b1;
                if (w_word_valid) begin
                    w_len_nxt = w_word;
                    if (w_word == 32'd0) begin
                        w_state_nxt    = DONE;
                        w_rx_ready_nxt = 1'b0;
                    end else if ({1'b0, w_word} > MAX_WORDS) begin
                        w_state_nxt    = ERR;
                        w_rx_ready_nxt = 1'b0;
                    end else begin
                        w_state_nxt = LOAD;
                        w_addr_nxt  = '0;
                        w_count_nxt = '0;
                    end
                end
            end

            LOAD: begin
                if (r_we) begin
                    // Strobe cycle just ended: advance. The address saturates
                    // at the top word so it never wraps back onto word 0.
                    w_count_nxt = w_count_inc;
                    if (r_addr != c_ADDR_MAX) begin
                        w_addr_nxt = r_addr + ADDR_W'(1);
                    end
                    if (w_count_inc == r_len) begin
                        w_state_nxt    = DONE;
                        w_rx_ready_nxt = 1'b0;
                    end else begin
                        w_rx_ready_nxt = 1'b1;
                    end
                end else if (w_word_valid) begin
                    // Drop ready for the strobe cycle so the advance above
                    // never races a new byte.
                    w_we_nxt       = 1'b1;
                    w_wdata_nxt    = w_word;
                    w_rx_ready_nxt = 1'b0;
                end else begin
                    w_rx_ready_nxt = 1'b1;
                end
            end

            DONE: begin
                w_rx_ready_nxt   = 1'b0;
                // Released only from the second DONE cycle onward: the DONE
                // entry cycle still sees r_state != DONE and keeps it high.
                w_core_reset_nxt = 1'b0;
                if (reload) begin
                    w_state_nxt      = LEN;
                    w_core_reset_nxt = 1'b1;
                    w_count_nxt      = '0;
                    w_clear          = 1'b1;
                end
            end

            ERR: begin
                w_rx_ready_nxt = 1'b0;
                if (reload) begin
                    w_state_nxt = LEN;
                    w_count_nxt = '0;
                    w_clear     = 1'b1;
                end
            end

            default: begin
                w_state_nxt = LEN;
            end
        endcase
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_reset = r_core_reset;
    assign word_count = r_count;
    assign load_done  = (r_state == DONE);
    assign load_err   = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_ctrl
//  Description : Self-checking bench for imem_boot_ctrl (ADDR_W=4, so programs
//                of up to 16 words). Expected writes and outcomes are derived
//                from the byte stream alone: header = LE length, then each
//                group of four bytes is one LE word at the next address.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_boot_ctrl;

    localparam int ADDR_W = 4;
    localparam int MAXW   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              load_done;
    logic              load_err;
    logic [31:0]       word_count;

    imem_boot_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int passed   = 0;
    int total    = 0;
    int timeouts = 0;

    // Observation side: records every write and rule violations.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int  strobe_rdy_viol = 0;
    int  cr_viol         = 0;
    int  idle_rdy_viol   = 0;
    int  done_entries    = 0;
    bit  prev_done       = 1'b0;
    bit  entry_pending   = 1'b0;
    logic entry_cr, after_cr;

    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                wr_addr.push_back(32'(imem_addr));
                wr_data.push_back(imem_wdata);
                if (rx_ready) strobe_rdy_viol++;
            end
            if (!load_done && !core_reset) cr_viol++;
            if ((load_done || load_err) && rx_ready) idle_rdy_viol++;
            if (entry_pending) begin
                after_cr      = core_reset;
                entry_pending = 1'b0;
            end
            if (load_done && !prev_done) begin
                entry_cr      = core_reset;
                entry_pending = 1'b1;
                done_entries++;
            end
        end
        prev_done = load_done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".rx_ready"},   32'(rx_ready),   32'd0);
        check({tag, ".imem_we"},    32'(imem_we),    32'd0);
        check({tag, ".imem_addr"},  32'(imem_addr),  32'd0);
        check({tag, ".imem_wdata"}, imem_wdata,      32'd0);
        check({tag, ".core_reset"}, 32'(core_reset), 32'd1);
        check({tag, ".load_done"},  32'(load_done),  32'd0);
        check({tag, ".load_err"},   32'(load_err),   32'd0);
        check({tag, ".word_count"}, word_count,      32'd0);
    endtask

    // Called right after a falling edge; returns right after the falling edge
    // that follows the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        budget = 50;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            timeouts++;
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [7:0] bytes[$],
                           input bit gaps, input bit reload_mid);
        logic [31:0] len, exp_word;
        bit   exp_err;
        int   nw, nsend, budget;
        int   wbase, dbase, sbase, cbase, ibase, tbase;

        if (load_done || load_err) pulse_reload();
        wbase = wr_addr.size();
        dbase = done_entries;
        sbase = strobe_rdy_viol;
        cbase = cr_viol;
        ibase = idle_rdy_viol;
        tbase = timeouts;

        len     = 32'(bytes[0]) + 32'(bytes[1]) * 256 + 32'(bytes[2]) * 65536
                + 32'(bytes[3]) * 16777216;
        exp_err = (len > 32'(MAXW));
        nw      = exp_err ? 0 : int'(len);
        nsend   = 4 + 4 * nw;

        for (int i = 0; i < nsend; i++) begin
            if (reload_mid && i == 6) pulse_reload();
            send_byte(bytes[i], gaps);
        end

        budget = 50;
        while (!(load_done || load_err) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) timeouts++;
        repeat (2) @(negedge clk);

        if (exp_err) begin
            // Trailing bytes offered in ERR must be ignored.
            rx_valid = 1'b1;
            for (int i = 0; i < 8; i++) begin
                rx_data = 8'($urandom);
                @(negedge clk);
            end
            rx_valid = 1'b0;
        end

        check({tag, ".load_done"},  32'(load_done),  32'(!exp_err));
        check({tag, ".load_err"},   32'(load_err),   32'(exp_err));
        check({tag, ".core_reset"}, 32'(core_reset), 32'(exp_err));
        check({tag, ".rx_ready"},   32'(rx_ready),   32'd0);
        check({tag, ".word_count"}, word_count,      exp_err ? 32'd0 : len);
        check({tag, ".nwrites"},    32'(wr_addr.size() - wbase), 32'(nw));
        for (int i = 0; i < nw && (wbase + i) < wr_addr.size(); i++) begin
            exp_word = 32'(bytes[4+4*i]) + 32'(bytes[5+4*i]) * 256
                     + 32'(bytes[6+4*i]) * 65536 + 32'(bytes[7+4*i]) * 16777216;
            check($sformatf("%s.addr%0d", tag, i), wr_addr[wbase+i], 32'(i));
            check($sformatf("%s.data%0d", tag, i), wr_data[wbase+i], exp_word);
        end
        check({tag, ".strobe_ready_low"}, 32'(strobe_rdy_viol - sbase), 32'd0);
        check({tag, ".core_reset_hold"},  32'(cr_viol - cbase),         32'd0);
        check({tag, ".idle_ready_low"},   32'(idle_rdy_viol - ibase),   32'd0);
        check({tag, ".timeouts"},         32'(timeouts - tbase),        32'd0);
        if (!exp_err) begin
            check({tag, ".done_entry"},        32'(done_entries - dbase), 32'd1);
            check({tag, ".core_reset_entry"},  32'(entry_cr),             32'd1);
            check({tag, ".core_reset_after"},  32'(after_cr),             32'd0);
        end
    endtask

    logic [7:0] nominal[$];
    logic [7:0] q[$];
    int         n;

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        nominal  = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00};

        // Reset values, and rx_ready stays low for the first post-reset cycle.
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        check("reset.rx_ready_rises", 32'(rx_ready), 32'd1);

        do_load("nominal", nominal, 1'b0, 1'b0);
        do_load("gapped", nominal, 1'b1, 1'b0);

        // Reload from DONE, then a one-word program.
        pulse_reload();
        check("reload.core_reset", 32'(core_reset), 32'd1);
        check("reload.load_done",  32'(load_done),  32'd0);
        check("reload.load_err",   32'(load_err),   32'd0);
        check("reload.word_count", word_count,      32'd0);
        q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_load("deadbeef", q, 1'b0, 1'b0);

        q = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_load("zero_len", q, 1'b1, 1'b0);

        // Random programs, the first at the full 16-word limit; reload pulsed
        // mid-load must be ignored.
        for (int it = 0; it < 4; it++) begin
            n = (it == 0) ? MAXW : int'($urandom_range(1, MAXW));
            q = {};
            q.push_back(8'(n));
            q.push_back(8'h00);
            q.push_back(8'h00);
            q.push_back(8'h00);
            for (int k = 0; k < 4 * n; k++) q.push_back(8'($urandom));
            do_load($sformatf("rand%0d", it), q, 1'($urandom_range(0, 1)), it == 1);
        end

        q = '{8'h17, 8'h00, 8'h00, 8'h00};
        do_load("oversize", q, 1'b0, 1'b0);
        q = '{8'h11, 8'h00, 8'h00, 8'h00};
        do_load("limit_plus1", q, 1'b1, 1'b0);
        q = '{8'h00, 8'h00, 8'h00, 8'h01};
        do_load("huge", q, 1'b0, 1'b0);

        // Reset after two bytes of word 1, then a fresh load from address 0.
        pulse_reload();
        for (int i = 0; i < 10; i++) send_byte(nominal[i], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b0;
        @(negedge clk);
        do_load("after_reset", nominal, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
